// File: rtl/ext_bus_initiator.sv
// Initiator for the 16-bit async chip-select register bus: valid/ready requests become timed cs/rd/wr cycles.
// Define EXT_BUS_INIT_WIDE_EN to split 32-bit requests into a low-half then high-half access.
module ext_bus_initiator #(
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned STROBE_CYCLES = 8,
  parameter int unsigned HOLD_CYCLES   = 2,
  parameter int unsigned GAP_CYCLES    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic        req_wide_i,
  input  logic [3:0]  req_idx_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic [24:0] bus_addr_o,
  output logic [1:0]  bus_cs_n_o,
  output logic        bus_rd_n_o,
  output logic        bus_wr_n_o,
  output logic [15:0] bus_data_o,
  output logic        bus_data_oe_o,
  input  logic [15:0] bus_data_i
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] STROBE = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] GAP    = 3'd4;

  // A zero-length setup phase starts each pass directly in STROBE.
  localparam logic [2:0] PASS_START  = (SETUP_CYCLES > 0) ? SETUP : STROBE;
  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LAST    = 8'(GAP_CYCLES - 1);

`ifdef EXT_BUS_INIT_WIDE_EN
  logic wide_in;
  assign wide_in = req_wide_i;
`else
  logic wide_in;
  logic unused_wide;
  assign wide_in     = 1'b0;
  assign unused_wide = req_wide_i;
`endif

  logic [2:0]  state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic        accept, pass_end, second, complete, drive, strobe_last;
  logic        wr_q, wide_q, half_q;
  logic        write_sel, half_sel;
  logic [3:0]  idx_q, idx_sel;
  logic [31:0] wdata_q, wdata_sel, acc_q, acc_n;
  logic [15:0] half_data;

  assign accept      = req_ready_o && req_valid_i;
  assign strobe_last = (state == STROBE) && (cnt == STROBE_LAST);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 8'd1;
    pass_end = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = 8'd0;
        if (accept) state_n = PASS_START;
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          cnt_n   = 8'd0;
          state_n = STROBE;
        end
      end
      STROBE: begin
        if (cnt == STROBE_LAST) begin
          cnt_n = 8'd0;
          if (HOLD_CYCLES > 0)     state_n  = HOLD;
          else if (GAP_CYCLES > 0) state_n  = GAP;
          else                     pass_end = 1'b1;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_n = 8'd0;
          if (GAP_CYCLES > 0) state_n  = GAP;
          else                pass_end = 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n    = 8'd0;
          pass_end = 1'b1;
        end
      end
      default: begin
        cnt_n   = 8'd0;
        state_n = IDLE;
      end
    endcase
    second   = pass_end && wide_q && !half_q;
    complete = pass_end && !second;
    if (second)        state_n = PASS_START;
    else if (complete) state_n = IDLE;
  end

  // Request fields as seen by the pass being entered: fresh on accept, idx+1 on the high half.
  always_comb begin
    write_sel = accept ? req_write_i : wr_q;
    wdata_sel = accept ? req_wdata_i : wdata_q;
    half_sel  = accept ? 1'b0 : (second ? 1'b1 : half_q);
    idx_sel   = accept ? req_idx_i : (second ? idx_q + 4'd1 : idx_q);
    half_data = half_sel ? wdata_sel[31:16] : wdata_sel[15:0];
    drive     = (state_n == SETUP) || (state_n == STROBE);
    acc_n     = accept ? 32'd0 : acc_q;
    if (strobe_last) begin
      if (half_q) acc_n[31:16] = bus_data_i;
      else        acc_n[15:0]  = bus_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    wr_q    <= write_sel;
    wdata_q <= wdata_sel;
    idx_q   <= idx_sel;
    acc_q   <= acc_n;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      half_q        <= 1'b0;
      wide_q        <= 1'b0;
      req_ready_o   <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= 32'd0;
      bus_addr_o    <= 25'd0;
      bus_cs_n_o    <= 2'b11;
      bus_rd_n_o    <= 1'b1;
      bus_wr_n_o    <= 1'b1;
      bus_data_o    <= 16'd0;
      bus_data_oe_o <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      half_q        <= half_sel;
      if (accept) wide_q <= wide_in;
      req_ready_o   <= (state_n == IDLE);
      rsp_valid_o   <= complete;
      if (complete) rsp_rdata_o <= acc_n;
      bus_cs_n_o    <= (state_n == STROBE) ? 2'b00 : 2'b11;
      bus_rd_n_o    <= !(drive && !write_sel);
      bus_wr_n_o    <= !(drive && write_sel);
      bus_data_oe_o <= write_sel && (drive || (state_n == HOLD));
      if (drive) bus_addr_o <= {20'd0, idx_sel, 1'b0};
      if (drive && write_sel) bus_data_o <= half_data;
    end
  end
endmodule

// File: tb/tb_ext_bus_initiator.sv
// Directed bench for ext_bus_initiator: a default-timing instance against a register-file
// responder model, plus a minimal-timing instance (SETUP=HOLD=GAP=0, STROBE=1).
module tb_ext_bus_initiator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid, req_write, req_wide;
  logic [3:0]  req_idx;
  logic [31:0] req_wdata;
  logic        req_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic [24:0] bus_addr;
  logic [1:0]  cs_n;
  logic        rd_n, wr_n, oe;
  logic [15:0] bus_wdata, bus_rdata;

  logic        valid_m, ready_m, rsp_valid_m, rd_n_m, wr_n_m, oe_m;
  logic [31:0] rdata_m;
  logic [24:0] addr_m;
  logic [1:0]  cs_n_m;
  logic [15:0] wdata_m;
  logic [15:0] pad_m = 16'hC3A5;

  logic [15:0] regs [16];
  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 16'hA000 + 16'(i);
    regs[0] = 16'h50FE;
  end
  assign bus_rdata = regs[bus_addr[4:1]];

  ext_bus_initiator dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_wide_i(req_wide), .req_idx_i(req_idx), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .bus_addr_o(bus_addr), .bus_cs_n_o(cs_n), .bus_rd_n_o(rd_n), .bus_wr_n_o(wr_n),
    .bus_data_o(bus_wdata), .bus_data_oe_o(oe), .bus_data_i(bus_rdata)
  );

  ext_bus_initiator #(.SETUP_CYCLES(0), .STROBE_CYCLES(1), .HOLD_CYCLES(0), .GAP_CYCLES(0)) u_min (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(valid_m), .req_ready_o(ready_m), .req_write_i(req_write),
    .req_wide_i(req_wide), .req_idx_i(req_idx), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid_m), .rsp_rdata_o(rdata_m),
    .bus_addr_o(addr_m), .bus_cs_n_o(cs_n_m), .bus_rd_n_o(rd_n_m), .bus_wr_n_o(wr_n_m),
    .bus_data_o(wdata_m), .bus_data_oe_o(oe_m), .bus_data_i(pad_m)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  // Bus monitor: one entry {wr_n, addr[7:0], data} per cs_n falling edge, strobe lengths, gaps, oe cycles.
  logic [31:0] acc_q [$];
  int          low_q [$];
  int          gap_q [$];
  int          low_run = 0, high_run = 0, oe_cnt = 0;
  logic [1:0]  prev_cs = 2'b11;
  bit          seen = 1'b0;

  always @(negedge clk) begin
    if (cs_n == 2'b00) begin
      if (prev_cs != 2'b00) begin
        if (seen) gap_q.push_back(high_run);
        seen = 1'b1;
        acc_q.push_back({7'd0, wr_n, bus_addr[7:0], bus_wdata});
        low_run = 0;
      end
      low_run++;
      high_run = 0;
    end else begin
      if (prev_cs == 2'b00) low_q.push_back(low_run);
      high_run++;
    end
    if (oe) oe_cnt++;
    prev_cs = cs_n;
  end

  function automatic logic [31:0] acc_at(int i);
    return (i < acc_q.size()) ? acc_q[i] : 32'hFFFF_FFFF;
  endfunction
  function automatic int low_at(int i);
    return (i < low_q.size()) ? low_q[i] : -1;
  endfunction
  function automatic int gap_at(int i);
    return (i < gap_q.size()) ? gap_q[i] : -1;
  endfunction

  // Issue one request, return read data and handshake-edge to rsp_valid-sampling-edge latency.
  task automatic do_req(input logic w, input logic wd, input logic [3:0] idx, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
    int t;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_wide = wd; req_idx = idx; req_wdata = d;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (rsp_valid) break;
    end
    rd  = rsp_rdata;
    lat = lat + 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lat, a0, l0, g0, o0, comps, t, extra, lows;
    int ctime [3];
    logic drop;
    req_valid = 1'b0; req_write = 1'b0; req_wide = 1'b0; req_idx = 4'd0; req_wdata = 32'd0;
    valid_m = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n",      32'(cs_n),      32'h3);
    check("rst_rd_n",      32'(rd_n),      32'h1);
    check("rst_wr_n",      32'(wr_n),      32'h1);
    check("rst_oe",        32'(oe),        32'h0);
    check("rst_data",      32'(bus_wdata), 32'h0);
    check("rst_addr",      32'(bus_addr),  32'h0);
    check("rst_ready",     32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rdata",     rsp_rdata,      32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 check("ready_after_rst", 32'(req_ready), 32'h1);

    // Sanity register read
    a0 = acc_q.size(); l0 = low_q.size();
    do_req(1'b0, 1'b0, 4'd0, 32'd0, rd, lat);
    check("sanity_rdata", rd, 32'h0000_50FE);
    check("sanity_lat",   32'(lat), 32'd17);
    check("sanity_n_acc", 32'(acc_q.size() - a0), 32'd1);
    check("sanity_addr",  acc_at(a0) >> 16, 32'h0000_0100);
    check("sanity_low",   32'(low_at(l0)), 32'd8);

    // Wide write
    a0 = acc_q.size(); l0 = low_q.size(); g0 = gap_q.size(); o0 = oe_cnt;
    do_req(1'b1, 1'b1, 4'd1, 32'hDEAD_BEEF, rd, lat);
`ifdef EXT_BUS_INIT_WIDE_EN
    check("wwr_lat",   32'(lat), 32'd33);
    check("wwr_n_acc", 32'(acc_q.size() - a0), 32'd2);
    check("wwr_acc0",  acc_at(a0),     32'h0002_BEEF);
    check("wwr_acc1",  acc_at(a0 + 1), 32'h0004_DEAD);
    check("wwr_low0",  32'(low_at(l0)),     32'd8);
    check("wwr_low1",  32'(low_at(l0 + 1)), 32'd8);
    check("wwr_gap",   32'(gap_at(g0 + 1)), 32'd8);
    check("wwr_oe",    32'(oe_cnt - o0), 32'd24);
    check("wwr_addr",  32'(bus_addr), 32'h4);
`else
    check("wwr_lat",   32'(lat), 32'd17);
    check("wwr_n_acc", 32'(acc_q.size() - a0), 32'd1);
    check("wwr_acc0",  acc_at(a0), 32'h0002_BEEF);
    check("wwr_low0",  32'(low_at(l0)), 32'd8);
    check("wwr_oe",    32'(oe_cnt - o0), 32'd12);
    check("wwr_addr",  32'(bus_addr), 32'h2);
`endif

    // Wide read at idx 15
    a0 = acc_q.size();
    do_req(1'b0, 1'b1, 4'd15, 32'd0, rd, lat);
`ifdef EXT_BUS_INIT_WIDE_EN
    check("wrd_rdata", rd, 32'h50FE_A00F);
    check("wrd_lat",   32'(lat), 32'd33);
    check("wrd_acc0",  acc_at(a0) >> 16,     32'h0000_011E);
    check("wrd_acc1",  acc_at(a0 + 1) >> 16, 32'h0000_0100);
`else
    check("wrd_rdata", rd, 32'h0000_A00F);
    check("wrd_lat",   32'(lat), 32'd17);
    check("wrd_acc0",  acc_at(a0) >> 16, 32'h0000_011E);
`endif

    // Back-to-back narrow writes with req_valid held
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_wide = 1'b0; req_idx = 4'd3; req_wdata = 32'h0000_1234;
    comps = 0; drop = 1'b0; t = 0;
    while (t < 200 && comps < 3) begin
      @(posedge clk);
      #1;
      t++;
      if (drop) begin
        req_valid = 1'b0;
        drop = 1'b0;
      end
      if (rsp_valid) begin
        ctime[comps] = t;
        check("b2b_ready_at_rsp", 32'(req_ready), 32'h1);
        comps++;
        if (comps == 2) drop = 1'b1;
      end
    end
    req_valid = 1'b0;
    check("b2b_comps", 32'(comps), 32'd3);
    check("b2b_gap01", 32'(ctime[1] - ctime[0]), 32'd17);
    check("b2b_gap12", 32'(ctime[2] - ctime[1]), 32'd17);
    extra = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (rsp_valid) extra++;
    end
    check("b2b_no_extra", 32'(extra), 32'd0);

    // Reset asserted during STROBE of a write
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_idx = 4'd5; req_wdata = 32'h0000_CAFE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_cs_low", 32'(cs_n), 32'h0);
    check("mid_oe",     32'(oe),   32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_cs_n",  32'(cs_n),      32'h3);
    check("mid_rst_rd_n",  32'(rd_n),      32'h1);
    check("mid_rst_wr_n",  32'(wr_n),      32'h1);
    check("mid_rst_oe",    32'(oe),        32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 check("mid_ready_after", 32'(req_ready), 32'h1);
    extra = 0; lows = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (rsp_valid) extra++;
      if (cs_n != 2'b11) lows++;
    end
    check("mid_no_rsp",  32'(extra), 32'd0);
    check("mid_bus_idle", 32'(lows), 32'd0);

    // Minimal-timing instance: narrow read at idx 7
    @(negedge clk);
    check("min_ready", 32'(ready_m), 32'h1);
    valid_m = 1'b1; req_write = 1'b0; req_wide = 1'b0; req_idx = 4'd7;
    @(posedge clk);
    #1 valid_m = 1'b0;
    check("min_cs_low",   32'(cs_n_m),      32'h0);
    check("min_rd_n",     32'(rd_n_m),      32'h0);
    check("min_wr_n",     32'(wr_n_m),      32'h1);
    check("min_addr",     32'(addr_m),      32'h0E);
    check("min_rsp_early", 32'(rsp_valid_m), 32'h0);
    @(posedge clk);
    #1;
    check("min_cs_high",  32'(cs_n_m),      32'h3);
    check("min_rsp",      32'(rsp_valid_m), 32'h1);
    check("min_rdata",    rdata_m,          32'h0000_C3A5);
    check("min_oe",       32'(oe_m),        32'h0);
    check("min_wdata",    32'(wdata_m),     32'h0);
    @(posedge clk);
    #1 check("min_rsp_pulse", 32'(rsp_valid_m), 32'h0);

    // Recovery read after the mid-access reset
    do_req(1'b0, 1'b0, 4'd2, 32'd0, rd, lat);
    check("recover_rdata", rd, 32'h0000_A002);
    check("recover_lat",   32'(lat), 32'd17);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
